prio_max_sel: RTL and testbench

//  Multi-cycle max-priority selector between the per-input VOQ priority stage and the grant arbiter.

---
 rtl/prio_max_sel_pkg.sv | 21 ++
 rtl/prio_max_sel_rr_pick.sv | 31 +++
 rtl/prio_max_sel.sv | 152 +++++++++++++++
 tb/tb_prio_max_sel.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/prio_max_sel_pkg.sv
// Shared types and width helpers for the prio_max_sel selector.
package prio_max_sel_pkg;

    // Selector sequencing: wait for a set, walk the bits, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a channel pointer (never below one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the bit-serial scan index (never below one bit).
    function automatic int bit_width(input int pw);
        return (pw > 1) ? $clog2(pw) : 1;
    endfunction

endpackage

// File: rtl/prio_max_sel_rr_pick.sv
// One-hot winner picker. With en_rr set, the search starts at ptr and wraps
// modulo N; with en_rr clear it is plain lowest-index-wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          en_rr,
    output logic [N-1:0]  gnt
);

    // First requesting channel at or after the search base wins.
    always_comb begin : pick_blk
        logic          found;
        logic [CW-1:0] idx;
        int            base;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        base  = en_rr ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = CW'((base + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_max_sel.sv
// Multi-cycle max-priority selector: MSB-first bit-serial narrowing of the
// candidate mask, early exit once at most one candidate remains, result held
// behind a valid/ready handshake.
// Build option: define PRIO_MAX_SEL_RR_TIEBREAK_EN for a round-robin tie
// breaker on gnt; otherwise the lowest-index candidate is granted.
module prio_max_sel
    import prio_max_sel_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*PW-1:0] pri_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  win_mask,
    output logic [PW-1:0] max_pri,
    output logic [N-1:0]  gnt
);

    localparam int CW = ptr_width(N);
    localparam int BW = bit_width(PW);

    state_t        state_reg, state_next;
    logic [PW-1:0] pri_arr   [N];
    logic [PW-1:0] data_reg  [N];
    logic [PW-1:0] data_next [N];
    logic [N-1:0]  cand_reg, cand_next;
    logic [N-1:0]  nz_mask, hits, cand_scan, pick_gnt;
    logic [BW-1:0] bit_reg, bit_next;
    logic [N-1:0]  win_mask_reg, gnt_reg;
    logic [PW-1:0] max_pri_reg, max_next;
    logic          load_out, nz_single, scan_single;
    logic [CW-1:0] ptr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign pri_arr[gi] = pri_in[gi*PW +: PW];
            assign nz_mask[gi] = |pri_arr[gi];
            assign hits[gi]    = cand_reg[gi] & data_reg[gi][bit_reg];
        end
    endgenerate

    // A hit-free bit leaves the candidate set untouched.
    assign cand_scan   = (|hits) ? hits : cand_reg;
    assign nz_single   = ((nz_mask & (nz_mask - N'(1))) == '0);
    assign scan_single = ((cand_scan & (cand_scan - N'(1))) == '0);

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign win_mask  = win_mask_reg;
    assign max_pri   = max_pri_reg;
    assign gnt       = gnt_reg;

`ifdef PRIO_MAX_SEL_RR_TIEBREAK_EN
    logic [CW-1:0] ptr_reg, ptr_adv;
    assign ptr_sel = ptr_reg;
    rr_pick #(.N(N), .CW(CW)) u_pick (
        .req   (cand_next),
        .ptr   (ptr_sel),
        .en_rr (1'b1),
        .gnt   (pick_gnt)
    );
`else
    assign ptr_sel = '0;
    rr_pick #(.N(N), .CW(CW)) u_pick (
        .req   (cand_next),
        .ptr   (ptr_sel),
        .en_rr (1'b0),
        .gnt   (pick_gnt)
    );
`endif

    // Next-state, scan datapath and result value for the DONE entry edge.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cand_next  = cand_reg;
        bit_next   = bit_reg;
        load_out   = 1'b0;
        max_next   = '0;
`ifdef PRIO_MAX_SEL_RR_TIEBREAK_EN
        ptr_adv = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_reg[i]) ptr_adv = CW'((i + 1) % N);
        end
`endif
        case (state_reg)
            IDLE, DONE: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < N; i++) data_next[i] = pri_arr[i];
                    cand_next = nz_mask;
                    bit_next  = BW'(PW - 1);
                    if (nz_single) begin
                        state_next = DONE;
                        load_out   = 1'b1;
                    end else begin
                        state_next = SCAN;
                    end
                end else if ((state_reg == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            SCAN: begin
                cand_next = cand_scan;
                if (bit_reg != '0) bit_next = bit_reg - BW'(1);
                if ((bit_reg == '0) || scan_single) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        for (int i = 0; i < N; i++) begin
            max_next = max_next | (data_next[i] & {PW{cand_next[i]}});
        end
    end

    // State and result registers; reset abandons any set in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            for (int i = 0; i < N; i++) data_reg[i] <= '0;
            cand_reg     <= '0;
            bit_reg      <= '0;
            win_mask_reg <= '0;
            max_pri_reg  <= '0;
            gnt_reg      <= '0;
`ifdef PRIO_MAX_SEL_RR_TIEBREAK_EN
            ptr_reg      <= '0;
`endif
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cand_reg  <= cand_next;
            bit_reg   <= bit_next;
            if (load_out) begin
                win_mask_reg <= cand_next;
                max_pri_reg  <= max_next;
                gnt_reg      <= pick_gnt;
            end
`ifdef PRIO_MAX_SEL_RR_TIEBREAK_EN
            if ((state_reg == DONE) && out_ready && (gnt_reg != '0)) ptr_reg <= ptr_adv;
`endif
        end
    end

endmodule

// File: tb/tb_prio_max_sel.sv
// Directed bench for prio_max_sel (N=4, PW=4). "lat" below is the number of
// clock edges after the accept edge until out_valid is seen high.
module tb_prio_max_sel;

`ifdef PRIO_MAX_SEL_RR_TIEBREAK_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] pri_in;
    logic [3:0]  win_mask, max_pri, gnt;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    prio_max_sel #(.N(4), .PW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pri_in    (pri_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .win_mask  (win_mask),
        .max_pri   (max_pri),
        .gnt       (gnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic [3:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Wait (bounded) for out_valid after the accept edge; returns edge count.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Push one set, check the result, then consume it.
    task automatic run_set(input string tag, input logic [15:0] pri, input logic [3:0] ew,
                           input logic [3:0] em, input logic [3:0] eg, input int elat);
        int lat;
        @(negedge clk);
        pri_in = pri; in_valid = 1'b1; out_ready = 1'b0;
        check_eq({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; pri_in = 16'hffff;
        wait_valid(lat);
        check_eq({tag, "_lat"}, lat, elat);
        check_eq({tag, "_win"}, win_mask, ew);
        check_eq({tag, "_max"}, max_pri, em);
        check_eq({tag, "_gnt"}, gnt, eg);
        $display("set %s pri=%h win=%b max=%0d gnt=%b lat=%0d", tag, pri, win_mask, max_pri, gnt, lat);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pri_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_win", win_mask, 0);
        check_eq("rst_max", max_pri, 0);
        check_eq("rst_gnt", gnt, 0);
        @(negedge clk); reset = 1'b0;

        run_set("tie99", pk(3, 9, 9, 2), 4'b0110, 4'd9, 4'b0010, 4);
        run_set("single5", pk(0, 0, 5, 0), 4'b0100, 4'd5, 4'b0100, 0);
        run_set("zero", pk(0, 0, 0, 0), 4'b0000, 4'd0, 4'b0000, 0);
        run_set("early8", pk(8, 4, 2, 1), 4'b0001, 4'd8, 4'b0001, 1);

        // Backpressure: result must hold while a new set waits on pri_in.
        @(negedge clk);
        pri_in = pk(6, 6, 1, 0); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        pri_in = pk(0, 0, 0, 3);
        wait_valid(lat);
        check_eq("bp_lat", lat, 4);
        check_eq("bp_win", win_mask, 4'b0011);
        check_eq("bp_max", max_pri, 6);
        check_eq("bp_gnt", gnt, RR ? 4'b0010 : 4'b0001);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_valid", out_valid, 1);
            check_eq("bp_hold_ready", in_ready, 0);
            check_eq("bp_hold_win", win_mask, 4'b0011);
            check_eq("bp_hold_max", max_pri, 6);
        end
        $display("set bp pri=%h win=%b max=%0d gnt=%b held 5 cycles", pk(6, 6, 1, 0), win_mask, max_pri, gnt);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
        check_eq("b2b_valid", out_valid, 1);
        check_eq("b2b_win", win_mask, 4'b1000);
        check_eq("b2b_max", max_pri, 3);
        check_eq("b2b_gnt", gnt, 4'b1000);
        $display("set b2b pri=%h win=%b max=%0d gnt=%b", pk(0, 0, 0, 3), win_mask, max_pri, gnt);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq("b2b_drained", out_valid, 0);

        // Leave the round-robin pointer non-zero before the reset test.
        run_set("one9", pk(0, 9, 0, 0), 4'b0010, 4'd9, 4'b0010, 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        pri_in = pk(7, 7, 7, 7); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("scan_busy_valid", out_valid, 0);
        check_eq("scan_busy_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_ready", in_ready, 1);
        @(negedge clk); reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("post_rst_quiet", out_valid, 0);
        end
        $display("mid-scan reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

        for (int k = 0; k < 4; k++) begin
            run_set("all7", pk(7, 7, 7, 7), 4'b1111, 4'd7, RR ? (4'b0001 << k) : 4'b0001, 4);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
